// File: rtl/codificador_instruccion_pkg.sv
// Shared definitions for the instruction encoder: RV32 opcodes for the supported
// formats, the tipo_i field encoding and the control FSM state type.
package codificador_instruccion_pkg;

  localparam logic [6:0] OP_TIPO_I = 7'b0010011;
  localparam logic [6:0] OP_TIPO_S = 7'b0100011;
  localparam logic [6:0] OP_TIPO_L = 7'b0000011;

  typedef enum logic [1:0] {
    TipoI        = 2'b00,
    TipoS        = 2'b01,
    TipoL        = 2'b10,
    TipoInvalido = 2'b11
  } tipo_e;

  typedef enum logic [1:0] {
    StInactivo,
    StCodifica,
    StFin
  } estado_e;

endpackage

// File: rtl/empaquetador_campos.sv
// Combinational field packer. Builds the 32-bit RV32 word for I/L/S formats and
// flags an immediate that does not fit in the sign-extended 12-bit field.
// Ports:
//   tipo_i        instruction format (tipo_e encoding)
//   rd_i/rs1_i/rs2_i/funct3_i  register and funct3 fields
//   inmediato_i   sign-extended immediate
//   instruccion_o packed instruction (0 for invalid format)
//   error_o       range error or invalid format
module empaquetador_campos
  import codificador_instruccion_pkg::*;
#(
  parameter int unsigned IMM = 20
) (
  input  logic [1:0]  tipo_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] inmediato_i,
  output logic [31:0] instruccion_o,
  output logic        error_o
);

  logic [IMM:0] signo;
  logic         rango_err;

  // The immediate is representable only if every bit above the encoded field
  // (plus the field's own sign bit) is a copy of the same value.
  assign signo     = inmediato_i[31:31-IMM];
  assign rango_err = !((&signo) || !(|signo));

  always_comb begin
    instruccion_o = '0;
    error_o       = rango_err;
    case (tipo_e'(tipo_i))
      TipoI: instruccion_o = {inmediato_i[11:0], rs1_i, funct3_i, rd_i, OP_TIPO_I};
      TipoL: instruccion_o = {inmediato_i[11:0], rs1_i, funct3_i, rd_i, OP_TIPO_L};
      TipoS: instruccion_o = {inmediato_i[11:5], rs2_i, rs1_i, funct3_i, inmediato_i[4:0],
                              OP_TIPO_S};
      default: begin
        instruccion_o = '0;
        error_o       = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/codificador_instruccion.sv
// Instruction encoder for loading an instruction memory. A session starts on
// inicio_i, accepts up to PROFUNDIDAD fields through a valid/ready input, and
// emits each encoded word with its byte address through a registered
// valid/ready output with one cycle of latency.
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   inicio_i, dir_base_i     session start and base byte address
//   valid_i, ready_o         input handshake
//   tipo_i, rd_i, rs1_i, rs2_i, funct3_i, inmediato_i  instruction fields
//   valid_o, ready_i         output handshake
//   instruccion_o, dir_o     encoded word and its address
//   error_o                  sticky encoding error for the session
//   hecho_o                  session complete and drained
module codificador_instruccion
  import codificador_instruccion_pkg::*;
#(
  parameter int unsigned IMM         = 20,
  parameter int unsigned PROFUNDIDAD = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inicio_i,
  input  logic [31:0] dir_base_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  tipo_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] inmediato_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instruccion_o,
  output logic [31:0] dir_o,
  output logic        error_o,
  output logic        hecho_o
);

  localparam int unsigned CntW = $clog2(PROFUNDIDAD + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(PROFUNDIDAD);

  estado_e         estado_q, estado_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     dir_q, dir_d;
  logic [31:0]     dir_out_q, dir_out_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;

  logic [31:0] instr_emp;
  logic        error_emp;
  logic        acepta_inicio;
  logic        acepta;

  empaquetador_campos #(
    .IMM (IMM)
  ) u_empaquetador (
    .tipo_i        (tipo_i),
    .rd_i          (rd_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .funct3_i      (funct3_i),
    .inmediato_i   (inmediato_i),
    .instruccion_o (instr_emp),
    .error_o       (error_emp)
  );

  assign acepta_inicio = inicio_i && (estado_q != StCodifica);
  assign ready_o       = (estado_q == StCodifica) && (cnt_q < CntMax) && (!valid_q || ready_i);
  assign acepta        = valid_i && ready_o;

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StInactivo: if (inicio_i) estado_d = StCodifica;
      StCodifica: if ((cnt_q == CntMax) && !valid_q) estado_d = StFin;
      StFin:      if (inicio_i) estado_d = StCodifica;
      default:    estado_d = StInactivo;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    dir_out_d = dir_out_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    error_d   = error_q;
    if (acepta_inicio) begin
      dir_d   = dir_base_i;
      cnt_d   = '0;
      error_d = 1'b0;
    end
    if (acepta) begin
      // A consumed word may be replaced in the same cycle, so valid stays high.
      instr_d   = instr_emp;
      dir_out_d = dir_q;
      dir_d     = dir_q + 32'd4;
      cnt_d     = cnt_q + 1'b1;
      valid_d   = 1'b1;
      error_d   = error_q | error_emp;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      estado_q  <= StInactivo;
      cnt_q     <= '0;
      dir_q     <= '0;
      dir_out_q <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      dir_out_q <= dir_out_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign valid_o       = valid_q;
  assign instruccion_o = instr_q;
  assign dir_o         = dir_out_q;
  assign error_o       = error_q;
  assign hecho_o       = (estado_q == StFin);

endmodule

// File: tb/tb_codificador_instruccion.sv
module tb_codificador_instruccion;

  localparam int unsigned Prof = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        inicio_i = 1'b0;
  logic [31:0] dir_base_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  tipo_i = '0;
  logic [4:0]  rd_i = '0;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rs2_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] inmediato_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instruccion_o;
  logic [31:0] dir_o;
  logic        error_o;
  logic        hecho_o;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] dir;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] exp_dir = '0;
  logic        exp_err = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  codificador_instruccion #(
    .IMM         (20),
    .PROFUNDIDAD (Prof)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .inicio_i      (inicio_i),
    .dir_base_i    (dir_base_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .tipo_i        (tipo_i),
    .rd_i          (rd_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .funct3_i      (funct3_i),
    .inmediato_i   (inmediato_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instruccion_o (instruccion_o),
    .dir_o         (dir_o),
    .error_o       (error_o),
    .hecho_o       (hecho_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference RV32 encodings.
  function automatic logic [31:0] enc(input logic [1:0] t, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [31:0] imm);
    case (t)
      2'b00:   return {imm[11:0], rs1, f3, rd, 7'b0010011};
      2'b01:   return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      2'b10:   return {imm[11:0], rs1, f3, rd, 7'b0000011};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic bad(input logic [1:0] t, input logic [31:0] imm);
    logic [20:0] hi;
    hi = imm[31:11];
    return (t == 2'b11) || !((hi == 21'h0) || (hi == 21'h1FFFFF));
  endfunction

  task automatic drive_fields(input logic [1:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [31:0] imm);
    tipo_i = t; rd_i = rd; rs1_i = rs1; rs2_i = rs2; funct3_i = f3; inmediato_i = imm;
  endtask

  task automatic push_expected();
    sb.push_back('{ins: enc(tipo_i, rd_i, rs1_i, rs2_i, funct3_i, inmediato_i), dir: exp_dir});
    exp_dir = exp_dir + 32'd4;
    if (bad(tipo_i, inmediato_i)) exp_err = 1'b1;
  endtask

  // Offers one input and waits (bounded) until it is accepted.
  task automatic send(input logic [1:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    int budget;
    budget = 20;
    drive_fields(t, rd, rs1, rs2, f3, imm);
    valid_i = 1'b1;
    #1;
    while (ready_o !== 1'b1 && budget > 0) begin
      @(posedge clk_i); #1;
      budget--;
    end
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept: ready_o=%b required 1", ready_o);
    end else begin
      push_expected();
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic start(input logic [31:0] base);
    inicio_i = 1'b1;
    dir_base_i = base;
    @(posedge clk_i); #1;
    inicio_i = 1'b0;
    exp_dir = base;
    exp_err = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({valid_o, ready_o, instruccion_o, dir_o, error_o, hecho_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b r=%b ins=%h dir=%h err=%b done=%b required all 0",
               valid_o, ready_o, instruccion_o, dir_o, error_o, hecho_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (ready_o !== 1'b0 || hecho_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: ready_o=%b hecho_o=%b required 0 0", ready_o, hecho_o);
    end
  endtask

  task automatic test_encode_i();
    start(32'h100);
    ready_i = 1'b1;
    send(2'b00, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL i_encode: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (valid_o !== 1'b1 || instruccion_o !== e.ins || dir_o !== e.dir) begin
        n_fail++;
        $display("FAIL i_encode: v=%b ins=%h dir=%h required v=1 ins=%h dir=%h",
                 valid_o, instruccion_o, dir_o, e.ins, e.dir);
      end
    end
    n_checks++;
    if (instruccion_o !== 32'hFFF1_0093 || dir_o !== 32'h100 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL i_encode_const: ins=%h dir=%h err=%b required fff10093 00000100 0",
               instruccion_o, dir_o, error_o);
    end
  endtask

  task automatic test_encode_s();
    send(2'b01, 5'd7, 5'd2, 5'd3, 3'd2, 32'h8);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL s_encode: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (valid_o !== 1'b1 || instruccion_o !== e.ins || dir_o !== e.dir ||
          error_o !== exp_err) begin
        n_fail++;
        $display("FAIL s_encode: v=%b ins=%h dir=%h err=%b required v=1 ins=%h dir=%h err=%b",
                 valid_o, instruccion_o, dir_o, error_o, e.ins, e.dir, exp_err);
      end
    end
    n_checks++;
    if (instruccion_o !== 32'h0031_2423 || dir_o !== 32'h104) begin
      n_fail++;
      $display("FAIL s_encode_const: ins=%h dir=%h required 00312423 00000104",
               instruccion_o, dir_o);
    end
  endtask

  task automatic test_range_error();
    int budget;
    send(2'b00, 5'd5, 5'd6, 5'd0, 3'd1, 32'h0000_0800);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL range_encode: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (instruccion_o !== e.ins || dir_o !== e.dir || error_o !== 1'b1) begin
        n_fail++;
        $display("FAIL range_encode: ins=%h dir=%h err=%b required ins=%h dir=%h err=1",
                 instruccion_o, dir_o, error_o, e.ins, e.dir);
      end
    end
    send(2'b10, 5'd3, 5'd4, 5'd0, 3'd2, 32'hFFFF_FFFC);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL l_encode: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (instruccion_o !== e.ins || dir_o !== e.dir || error_o !== exp_err) begin
        n_fail++;
        $display("FAIL l_encode: ins=%h dir=%h err=%b required ins=%h dir=%h err=%b",
                 instruccion_o, dir_o, error_o, e.ins, e.dir, exp_err);
      end
    end
    budget = 10;
    while (hecho_o !== 1'b1 && budget > 0) begin
      @(posedge clk_i); #1;
      budget--;
    end
    n_checks++;
    if (hecho_o !== 1'b1 || error_o !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL range_sticky: hecho=%b err=%b v=%b required 1 1 0", hecho_o, error_o, valid_o);
    end
    start(32'h200);
    n_checks++;
    if (error_o !== 1'b0 || hecho_o !== 1'b0) begin
      n_fail++;
      $display("FAIL range_clear: err=%b hecho=%b required 0 0", error_o, hecho_o);
    end
  endtask

  // Four inputs held back-to-back, then a fifth that must never be accepted.
  task automatic test_completion();
    int budget;
    for (int i = 0; i < 4; i++) begin
      drive_fields(2'b00, 5'(i + 1), 5'(i + 2), 5'd0, 3'(i), 32'(i * 40 - 60));
      valid_i = 1'b1;
      #1;
      n_checks++;
      if (ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: ready_o=%b required 1", i, ready_o);
      end else begin
        push_expected();
      end
      @(posedge clk_i); #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL b2b_word[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (valid_o !== 1'b1 || instruccion_o !== e.ins || dir_o !== e.dir) begin
          n_fail++;
          $display("FAIL b2b_word[%0d]: v=%b ins=%h dir=%h required v=1 ins=%h dir=%h",
                   i, valid_o, instruccion_o, dir_o, e.ins, e.dir);
        end
      end
    end
    drive_fields(2'b00, 5'd9, 5'd9, 5'd0, 3'd0, 32'd1);
    budget = 10;
    while (hecho_o !== 1'b1 && budget > 0) begin
      n_checks++;
      if (ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL fifth_rejected: ready_o=%b required 0", ready_o);
      end
      @(posedge clk_i); #1;
      budget--;
    end
    n_checks++;
    if (hecho_o !== 1'b1 || valid_o !== 1'b0 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL completion: hecho=%b v=%b r=%b required 1 0 0", hecho_o, valid_o, ready_o);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] a_ins;
    start(32'hFFFF_FFF8);
    ready_i = 1'b0;
    send(2'b00, 5'd8, 5'd9, 5'd0, 3'd3, 32'd100);
    a_ins = '0;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL bp_first: scoreboard empty");
    end else begin
      e = sb.pop_front();
      a_ins = e.ins;
      if (valid_o !== 1'b1 || instruccion_o !== e.ins || dir_o !== 32'hFFFF_FFF8) begin
        n_fail++;
        $display("FAIL bp_first: v=%b ins=%h dir=%h required v=1 ins=%h dir=fffffff8",
                 valid_o, instruccion_o, dir_o, e.ins);
      end
    end
    drive_fields(2'b01, 5'd0, 5'd10, 5'd11, 3'd1, 32'hFFFF_FF80);
    valid_i = 1'b1;
    repeat (5) begin
      n_checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || instruccion_o !== a_ins ||
          dir_o !== 32'hFFFF_FFF8) begin
        n_fail++;
        $display("FAIL bp_hold: r=%b v=%b ins=%h dir=%h required r=0 v=1 ins=%h dir=fffffff8",
                 ready_o, valid_o, instruccion_o, dir_o, a_ins);
      end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: ready_o=%b required 1", ready_o);
    end else begin
      push_expected();
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL bp_replace: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (valid_o !== 1'b1 || instruccion_o !== e.ins || dir_o !== e.dir) begin
        n_fail++;
        $display("FAIL bp_replace: v=%b ins=%h dir=%h required v=1 ins=%h dir=%h",
                 valid_o, instruccion_o, dir_o, e.ins, e.dir);
      end
    end
    // Invalid format at the wrapped address.
    send(2'b11, 5'd1, 5'd1, 5'd1, 3'd1, 32'd1);
    n_checks++;
    if (instruccion_o !== 32'h0 || dir_o !== 32'h0 || error_o !== 1'b1 || valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_wrap: ins=%h dir=%h err=%b v=%b required 0 0 1 1",
               instruccion_o, dir_o, error_o, valid_o);
    end
    void'(sb.pop_front());
  endtask

  task automatic test_async_reset();
    send(2'b10, 5'd12, 5'd13, 5'd0, 3'd4, 32'd16);
    ready_i = 1'b0;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL pre_reset: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (valid_o !== 1'b1 || instruccion_o !== e.ins || dir_o !== 32'h4 || error_o !== 1'b1) begin
        n_fail++;
        $display("FAIL pre_reset: v=%b ins=%h dir=%h err=%b required v=1 ins=%h dir=4 err=1",
                 valid_o, instruccion_o, dir_o, error_o, e.ins);
      end
    end
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({valid_o, ready_o, instruccion_o, dir_o, error_o, hecho_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b r=%b ins=%h dir=%h err=%b done=%b required all 0",
               valid_o, ready_o, instruccion_o, dir_o, error_o, hecho_o);
    end
    @(negedge clk_i) rst_i = 1'b0;
    ready_i = 1'b1;
    valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      n_checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b0 || hecho_o !== 1'b0) begin
        n_fail++;
        $display("FAIL no_resume: r=%b v=%b done=%b required 0 0 0", ready_o, valid_o, hecho_o);
      end
    end
    valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_encode_i();
    test_encode_s();
    test_range_error();
    test_completion();
    test_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/codificador_instruccion.md
CODIFICADOR_INSTRUCCION -- requirements
Module: codificador_instruccion

Interface
REQ-001 Parameter IMM, default 20: number of sign bits the matching decoder prepends; immediate range check spans inmediato_i[31:31-IMM].
REQ-002 Parameter PROFUNDIDAD, default 64: instructions per load session, at least 1.
REQ-003 Ports, in order:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- inicio_i  in  1  session start pulse.
- dir_base_i  in  32  byte address of first instruction, sampled on accepted inicio_i.
- valid_i  in  1  input fields valid.
- ready_o  out  1  input accepted when valid_i&&ready_o.
- tipo_i  in  2  00=I (0010011), 01=S (0100011), 10=L (0000011), 11=invalid.
- rd_i, rs1_i, rs2_i  in  5 each  register fields.
- funct3_i  in  3  funct3 field.
- inmediato_i  in  32  sign-extended immediate.
- valid_o  out  1  encoded word valid.
- ready_i  in  1  instruction memory accepts word.
- instruccion_o  out  32  encoded instruction.
- dir_o  out  32  byte address of instruccion_o.
- error_o  out  1  sticky encoding error.
- hecho_o  out  1  session complete.

Function
REQ-004 FSM states: INACTIVO, CODIFICA, FIN.
REQ-005 INACTIVO->CODIFICA on inicio_i: load dir_base_i into the address register, clear the entry counter and error_o.
REQ-006 inicio_i is ignored in CODIFICA. In FIN it behaves as in REQ-005 and clears hecho_o.
REQ-007 ready_o = (state==CODIFICA) && (counter<PROFUNDIDAD) && (!valid_o || ready_i). ready_o is 0 in INACTIVO and FIN.
REQ-008 On an accepted input, next cycle:
- instruccion_o and dir_o hold the encoding and its address; valid_o=1.
- counter increments; address register increments by 4.
- Latency is exactly 1 cycle.
REQ-009 Encodings:
- I/L: {imm[11:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- rd_i is ignored for S; rs2_i is ignored for I/L.
REQ-010 Range error: bits inmediato_i[31:31-IMM] not all equal. The low 12 bits are still encoded and error_o is set.
REQ-011 tipo_i=11: instruccion_o=32'b0 is emitted at the normal address and error_o is set.
REQ-012 error_o stays set until the next accepted inicio_i or reset.
REQ-013 valid_o with ready_i=0: instruccion_o, dir_o and valid_o hold stable.
REQ-014 valid_o&&ready_i with a simultaneous accepted input: the register is replaced and valid_o stays 1. Without a new input, valid_o clears.
REQ-015 Address register wraps modulo 2^32 without flagging.
REQ-016 CODIFICA->FIN when counter==PROFUNDIDAD and valid_o==0 (fully drained). hecho_o=1 while in FIN.

Reset
REQ-017 rst_i asserted: immediately, with no clock edge, state=INACTIVO and all outputs are 0: valid_o, ready_o, instruccion_o, dir_o, error_o, hecho_o.
REQ-018 Reset mid-session discards any pending word. The session does not resume on deassertion.

Structure
REQ-019 A shared package holds:
- opcode constants OP_TIPO_I=0010011, OP_TIPO_S=0100011, OP_TIPO_L=0000011;
- the tipo_i encoding;
- the FSM state typedef.
REQ-020 One combinational sub-module, empaquetador_campos, holds the field packing and range check. The parent holds the FSM, counter, address register and output register.

Verification
REQ-021 Bench scenarios:
- I encode: inicio with base 0x100; tipo I, rd=1, rs1=2, funct3=0, imm=-1 -> next cycle instruccion_o=0xFFF10093, dir_o=0x100, error_o=0.
- S encode: rs1=2, rs2=3, funct3=2, imm=8 -> instruccion_o=0x00312423 at dir_o=0x104.
- Range error: imm=0x00000800 -> low bits encoded, error_o=1 until next inicio.
- Backpressure: hold ready_i=0 for 5 cycles -> ready_o=0 and instruccion_o stable. Release -> in the same cycle a new input is accepted and the word replaced.
- Completion: PROFUNDIDAD=4, four entries, then drain -> hecho_o=1. A fifth valid_i is not accepted.
- Async reset: rst_i asserted mid-session between edges -> outputs 0 immediately, state INACTIVO.
